// File: rtl/cpu_mem_pkg.sv
// Shared types for the memory-stage front end: lane vectors, FSM states and
// the latched read-modify-write context.
package cpu_mem_pkg;
  localparam int NLANES     = 4;
  localparam int DMEM_WORDS = 256;

  typedef logic [NLANES-1:0][31:0] lane_vec_t;

  typedef enum logic {S_IDLE, S_RMW} state_t;

  typedef struct packed {
    lane_vec_t addr;
    lane_vec_t data;
  } rmw_t;
endpackage

// File: rtl/lane_addr_gen.sv
// Strided lane address generator: addr[i] = base + i*stride (32-bit wrap),
// plus a per-lane flag for addresses beyond the end of dmem.
module lane_addr_gen
  import cpu_mem_pkg::*;
#(
  parameter int LIMIT_WORDS = 256
) (
  input  logic [31:0]       base,
  input  logic [31:0]       stride,
  output lane_vec_t         addr,
  output logic [NLANES-1:0] oor
);
  localparam logic [31:0] LIMIT = 32'(LIMIT_WORDS);

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    assign addr[i] = base + stride * 32'(i);
    assign oor[i]  = (addr[i] >= LIMIT);
  end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage front end: issues scalar/vector loads and stores to dmem,
// registers results toward WB, and runs partial-mask vector stores as RMW.
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int DMEM_WORDS = cpu_mem_pkg::DMEM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_vec,
  input  logic              req_we,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_stride,
  input  logic [NLANES-1:0] req_mask,
  input  logic [31:0]       req_wd,
  input  lane_vec_t         req_wdv,
  output logic              dm_we,
  output logic              dm_wev,
  output logic [31:0]       dm_a,
  output logic [31:0]       dm_wd,
  output lane_vec_t         dm_va,
  output lane_vec_t         dm_wdv,
  input  logic [31:0]       dm_rd,
  input  lane_vec_t         dm_rdv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_load,
  output logic [31:0]       out_rd,
  output lane_vec_t         out_rdv,
  output logic              out_err
);
  state_t      state_q, state_d;
  rmw_t        rmw_q, rmw_d;
  logic        out_valid_q, out_valid_d;
  logic        out_is_load_q, out_is_load_d;
  logic        out_err_q, out_err_d;
  logic [31:0] out_rd_q, out_rd_d;
  lane_vec_t   out_rdv_q, out_rdv_d;

  lane_vec_t         lane_addr;
  logic [NLANES-1:0] lane_oor;
  logic              accept, req_err, mask_all, mask_any;

  lane_addr_gen #(.LIMIT_WORDS(DMEM_WORDS)) u_addr (
    .base   (req_base),
    .stride (req_stride),
    .addr   (lane_addr),
    .oor    (lane_oor)
  );

  // Lane 0 is the base address, so its flag doubles as the scalar range check.
  assign req_err  = req_is_vec ? |(lane_oor & req_mask) : lane_oor[0];
  assign mask_all = &req_mask;
  assign mask_any = |req_mask;

  always_comb begin
    state_d       = state_q;
    rmw_d         = rmw_q;
    out_valid_d   = out_valid_q & ~out_ready;
    out_is_load_d = out_is_load_q;
    out_err_d     = out_err_q;
    out_rd_d      = out_rd_q;
    out_rdv_d     = out_rdv_q;
    dm_we         = 1'b0;
    dm_wev        = 1'b0;
    dm_a          = '0;
    dm_wd         = '0;
    dm_va         = '0;
    dm_wdv        = '0;
    // Gating with reset keeps the combinational dmem path quiet while in reset.
    req_ready     = ~reset & (state_q == S_IDLE) & (~out_valid_q | out_ready);
    accept        = req_valid & req_ready;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          out_valid_d   = 1'b1;
          out_is_load_d = ~req_we;
          out_err_d     = req_err;
          out_rd_d      = '0;
          out_rdv_d     = '0;
          if (!req_is_vec) begin
            dm_a = req_base;
            if (req_we) begin
              dm_wd = req_wd;
              dm_we = ~req_err;
            end else if (!req_err) begin
              out_rd_d = dm_rd;
            end
          end else if (!req_we) begin
            dm_va = lane_addr;
            if (!req_err) begin
              for (int i = 0; i < NLANES; i++)
                out_rdv_d[i] = req_mask[i] ? dm_rdv[i] : 32'h0;
            end
          end else if (!req_err && mask_any) begin
            dm_va = lane_addr;
            if (mask_all) begin
              dm_wdv = req_wdv;
              dm_wev = 1'b1;
            end else begin
              // Merge against the current contents read this cycle; write next cycle.
              rmw_d.addr = lane_addr;
              for (int i = 0; i < NLANES; i++)
                rmw_d.data[i] = req_mask[i] ? req_wdv[i] : dm_rdv[i];
              out_valid_d = 1'b0;
              state_d     = S_RMW;
            end
          end
        end
      end
      S_RMW: begin
        dm_va         = rmw_q.addr;
        dm_wdv        = rmw_q.data;
        dm_wev        = 1'b1;
        out_valid_d   = 1'b1;
        out_is_load_d = 1'b0;
        out_err_d     = 1'b0;
        out_rd_d      = '0;
        out_rdv_d     = '0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rmw_q         <= '0;
      out_valid_q   <= 1'b0;
      out_is_load_q <= 1'b0;
      out_err_q     <= 1'b0;
      out_rd_q      <= '0;
      out_rdv_q     <= '0;
    end else begin
      state_q       <= state_d;
      rmw_q         <= rmw_d;
      out_valid_q   <= out_valid_d;
      out_is_load_q <= out_is_load_d;
      out_err_q     <= out_err_d;
      out_rd_q      <= out_rd_d;
      out_rdv_q     <= out_rdv_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_is_load = out_is_load_q;
  assign out_err     = out_err_q;
  assign out_rd      = out_rd_q;
  assign out_rdv     = out_rdv_q;
endmodule
